jedro_1_alu_issue: RTL and testbench

// Decode/issue stage feeding jedro_1_alu: takes a fetched RV32I instruction, reads the register file,

---
 rtl/jedro_1_alu_issue_if.sv | 10 +
 rtl/jedro_1_alu_issue.sv | 162 ++++++++++++++++
 tb/tb_jedro_1_alu_issue.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jedro_1_alu_issue_if.sv
// Fetch-to-issue instruction handshake: instruction word and PC qualified by valid/ready.
interface jedro_1_alu_issue_if;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [31:0] instr_addr_i;

  modport master (output instr_valid_i, instr_i, instr_addr_i, input instr_ready_o);
  modport slave  (input instr_valid_i, instr_i, instr_addr_i, output instr_ready_o);
endinterface

// File: rtl/jedro_1_alu_issue.sv
// RV32I decode/issue stage for jedro_1_alu: decodes OP/OP-IMM/LUI/AUIPC, reads the regfile,
// registers select/operands into the ALU and stalls fetch on read-after-write hazards.
module jedro_1_alu_issue (
  input  logic                clk_i,
  input  logic                rstn_i,
  jedro_1_alu_issue_if.slave  fetch,
  output logic [4:0]          rf_addr_a_o,
  output logic [4:0]          rf_addr_b_o,
  input  logic [31:0]         rf_data_a_i,
  input  logic [31:0]         rf_data_b_i,
  input  logic [4:0]          alu_dest_addr_i,
  input  logic                alu_wb_i,
  output logic [3:0]          sel_o,
  output logic [31:0]         op_a_o,
  output logic [31:0]         op_b_o,
  output logic [4:0]          dest_addr_o,
  output logic                wb_o,
  output logic                illegal_o
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [3:0] SEL_ADD   = 4'b0000;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_u, rs1_val, rs2_val;

  logic        legal, use_a, use_b, wr_dec;
  logic [3:0]  sel_dec;
  logic [31:0] a_dec, b_dec;
  logic        hazard, accept;

  logic [3:0]  sel_q, sel_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [4:0]  dest_q, dest_d;
  logic        wb_q, wb_d, illegal_q, illegal_d;

  assign opcode  = fetch.instr_i[6:0];
  assign rd      = fetch.instr_i[11:7];
  assign funct3  = fetch.instr_i[14:12];
  assign rs1     = fetch.instr_i[19:15];
  assign rs2     = fetch.instr_i[24:20];
  assign funct7  = fetch.instr_i[31:25];
  assign imm_i   = {{20{fetch.instr_i[31]}}, fetch.instr_i[31:20]};
  assign imm_u   = {fetch.instr_i[31:12], 12'b0};

  assign rf_addr_a_o = rs1;
  assign rf_addr_b_o = rs2;
  // x0 reads as zero whatever the regfile returns
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_data_a_i;
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_data_b_i;

  function automatic logic src_busy(input logic [4:0] a, input logic [4:0] d_q, input logic w_q,
                                    input logic [4:0] d_alu, input logic w_alu);
    return (a != 5'd0) && ((w_q && (d_q == a)) || (w_alu && (d_alu == a)));
  endfunction

  always_comb begin
    legal   = 1'b0;
    use_a   = 1'b0;
    use_b   = 1'b0;
    wr_dec  = 1'b0;
    sel_dec = SEL_ADD;
    a_dec   = 32'd0;
    b_dec   = 32'd0;
    case (opcode)
      OPC_OP: begin
        if ((funct7 == 7'b0000000) ||
            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          legal   = 1'b1;
          use_a   = 1'b1;
          use_b   = 1'b1;
          wr_dec  = 1'b1;
          sel_dec = {funct7[5], funct3};
          a_dec   = rs1_val;
          b_dec   = rs2_val;
        end
      end
      OPC_IMM: begin
        legal = 1'b1;
        if (funct3 == 3'b001) legal = (funct7 == 7'b0000000);
        if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        if (legal) begin
          use_a   = 1'b1;
          wr_dec  = 1'b1;
          sel_dec = {(funct3 == 3'b101) & funct7[5], funct3};
          a_dec   = rs1_val;
          b_dec   = imm_i;
        end
      end
      OPC_LUI: begin
        legal  = 1'b1;
        wr_dec = 1'b1;
        b_dec  = imm_u;
      end
      OPC_AUIPC: begin
        legal  = 1'b1;
        wr_dec = 1'b1;
        a_dec  = fetch.instr_addr_i;
        b_dec  = imm_u;
      end
      default: ;
    endcase
  end

  // A source is blocked while its producer sits in our output register or in the ALU
  assign hazard = (use_a && src_busy(rs1, dest_q, wb_q, alu_dest_addr_i, alu_wb_i)) ||
                  (use_b && src_busy(rs2, dest_q, wb_q, alu_dest_addr_i, alu_wb_i));
  assign fetch.instr_ready_o = ~(fetch.instr_valid_i & hazard);
  assign accept = fetch.instr_valid_i & fetch.instr_ready_o;

  always_comb begin
    sel_d     = SEL_ADD;
    op_a_d    = 32'd0;
    op_b_d    = 32'd0;
    dest_d    = 5'd0;
    wb_d      = 1'b0;
    illegal_d = 1'b0;
    if (accept) begin
      if (legal) begin
        sel_d  = sel_dec;
        op_a_d = a_dec;
        op_b_d = b_dec;
        dest_d = rd;
        wb_d   = wr_dec & (rd != 5'd0);
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sel_q     <= SEL_ADD;
      op_a_q    <= 32'd0;
      op_b_q    <= 32'd0;
      dest_q    <= 5'd0;
      wb_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      dest_q    <= dest_d;
      wb_q      <= wb_d;
      illegal_q <= illegal_d;
    end
  end

  assign sel_o       = sel_q;
  assign op_a_o      = op_a_q;
  assign op_b_o      = op_b_q;
  assign dest_addr_o = dest_q;
  assign wb_o        = wb_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_jedro_1_alu_issue.sv
// Bench for jedro_1_alu_issue: directed RV32I cases plus a random stream checked against an
// instruction-level model with a per-register busy-until scoreboard and a behavioural ALU/regfile.
module tb_jedro_1_alu_issue;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  rf_addr_a, rf_addr_b, alu_dest, dest;
  logic [31:0] rf_data_a, rf_data_b, op_a, op_b, alu_res;
  logic [3:0]  sel;
  logic        alu_wb, wb, ill;

  logic [31:0] rf [32];
  logic [31:0] model_regs [32];
  int          busy [32];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        wb;
    logic        ill;
    logic        ua;
    logic        ub;
  } exp_t;
  exp_t exp_out;

  jedro_1_alu_issue_if fif ();

  jedro_1_alu_issue dut (
    .clk_i(clk), .rstn_i(rstn), .fetch(fif.slave),
    .rf_addr_a_o(rf_addr_a), .rf_addr_b_o(rf_addr_b),
    .rf_data_a_i(rf_data_a), .rf_data_b_i(rf_data_b),
    .alu_dest_addr_i(alu_dest), .alu_wb_i(alu_wb),
    .sel_o(sel), .op_a_o(op_a), .op_b_o(op_b), .dest_addr_o(dest), .wb_o(wb), .illegal_o(ill)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'd0:    return a + b;
      4'd8:    return a - b;
      4'd1:    return a << b[4:0];
      4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a ^ b;
      4'd5:    return a >> b[4:0];
      4'd13:   return $unsigned($signed(a) >>> b[4:0]);
      4'd6:    return a | b;
      4'd7:    return a & b;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Behavioural ALU plus regfile write-back; x0 holds garbage to prove the stage masks it
  assign rf_data_a = rf[rf_addr_a];
  assign rf_data_b = rf[rf_addr_b];
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alu_wb   <= 1'b0;
      alu_dest <= 5'd0;
      alu_res  <= 32'd0;
    end else begin
      alu_wb   <= wb;
      alu_dest <= dest;
      alu_res  <= alu_ref(sel, op_a, op_b);
      if (alu_wb) rf[alu_dest] <= alu_res;
    end
  end

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e = '0;
    logic [6:0]  opc = ins[6:0];
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [4:0]  rd = ins[11:7];
    logic [31:0] v1 = model_regs[ins[19:15]];
    logic [31:0] v2 = model_regs[ins[24:20]];
    logic [31:0] sx = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] up = {ins[31:12], 12'h000};
    if (opc == 7'h33) begin
      if (f7 == 7'h00)                    e.sel = {1'b0, f3};
      else if (f7 == 7'h20 && f3 == 3'd0) e.sel = 4'd8;
      else if (f7 == 7'h20 && f3 == 3'd5) e.sel = 4'd13;
      else                                e.ill = 1'b1;
      if (!e.ill) begin e.a = v1; e.b = v2; e.ua = 1'b1; e.ub = 1'b1; end
    end else if (opc == 7'h13) begin
      e.sel = {1'b0, f3};
      if (f3 == 3'd1 && f7 != 7'h00) e.ill = 1'b1;
      if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) e.ill = 1'b1;
      if (f3 == 3'd5 && f7 == 7'h20) e.sel = 4'd13;
      if (!e.ill) begin e.a = v1; e.b = sx; e.ua = 1'b1; end
    end else if (opc == 7'h37) begin
      e.b = up;
    end else if (opc == 7'h17) begin
      e.a = pc; e.b = up;
    end else begin
      e.ill = 1'b1;
    end
    if (e.ill) e = '{sel: 4'd0, a: 32'd0, b: 32'd0, dest: 5'd0, wb: 1'b0, ill: 1'b1, ua: 1'b0, ub: 1'b0};
    else begin e.dest = rd; e.wb = (rd != 5'd0); end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_out();
    chk("sel", {28'd0, sel}, {28'd0, exp_out.sel});
    chk("op_a", op_a, exp_out.a);
    chk("op_b", op_b, exp_out.b);
    chk("dest", {27'd0, dest}, {27'd0, exp_out.dest});
    chk("wb", {31'd0, wb}, {31'd0, exp_out.wb});
    chk("illegal", {31'd0, ill}, {31'd0, exp_out.ill});
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc, output logic acc);
    exp_t e;
    logic hz;
    check_out();
    fif.instr_valid_i = v;
    fif.instr_i       = ins;
    fif.instr_addr_i  = pc;
    #1;
    e  = model(ins, pc);
    hz = v && ((e.ua && ins[19:15] != 5'd0 && busy[ins[19:15]] >= cyc) ||
               (e.ub && ins[24:20] != 5'd0 && busy[ins[24:20]] >= cyc));
    chk("ready", {31'd0, fif.instr_ready_o}, {31'd0, !hz});
    chk("rf_addr_a", {27'd0, rf_addr_a}, {27'd0, ins[19:15]});
    chk("rf_addr_b", {27'd0, rf_addr_b}, {27'd0, ins[24:20]});
    acc = v && !hz;
    if (acc) begin
      exp_out = e;
      if (e.wb) begin
        busy[e.dest]       = cyc + 2;
        model_regs[e.dest] = alu_ref(e.sel, e.a, e.b);
      end
    end else begin
      exp_out = '0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, output int stalls);
    logic acc;
    stalls = 0;
    step(1'b1, ins, pc, acc);
    while (!acc && stalls < 4) begin
      stalls++;
      step(1'b1, ins, pc, acc);
    end
    chk("accept_bound", {31'd0, acc}, 32'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    fif.instr_valid_i = 1'b0;
    #1;
    exp_out = '0;
    check_out();
    chk("ready_in_reset", {31'd0, fif.instr_ready_o}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      busy[i]       = -10;
      model_regs[i] = (i == 0) ? 32'd0 : rf[i];
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] rand_instr();
    int         k   = $urandom_range(0, 9);
    logic [4:0] rd  = 5'($urandom_range(0, 7));
    logic [4:0] rs1 = 5'($urandom_range(0, 7));
    logic [4:0] rs2 = 5'($urandom_range(0, 7));
    logic [2:0] f3  = 3'($urandom_range(0, 7));
    logic [6:0] f7s [3] = '{7'h00, 7'h20, 7'h01};
    logic [6:0] f7  = f7s[$urandom_range(0, 2)];
    logic [11:0] imm = 12'($urandom);
    if (k <= 2) return enc_r(f7, rs2, rs1, f3, rd);
    if (k <= 5) begin
      if (f3 == 3'd1 || f3 == 3'd5) imm = {f7, 5'($urandom)};
      return enc_i(imm, rs1, f3, rd, 7'h13);
    end
    if (k == 6) return {20'($urandom), rd, 7'h37};
    if (k == 7) return {20'($urandom), rd, 7'h17};
    if (k == 8) return enc_i(imm, rs1, 3'd2, rd, 7'h03);
    return enc_i(imm, rs1, f3, rd, 7'h12);
  endfunction

  initial begin
    int   st;
    logic acc;
    fif.instr_valid_i = 1'b0;
    fif.instr_i       = 32'd0;
    fif.instr_addr_i  = 32'd0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom | 32'd1;
    @(negedge clk);
    do_reset();

    issue(32'hFFB00093, 32'h0, st);
    chk("addi_op_b", op_b, 32'hFFFFFFFB);
    chk("addi_dest", {27'd0, dest}, 32'd1);

    issue(enc_i(12'd7, 5'd0, 3'd0, 5'd1, 7'h13), 32'h4, st);
    issue(enc_i(12'd9, 5'd0, 3'd0, 5'd2, 7'h13), 32'h8, st);
    issue(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'hC, st);
    chk("sub_sel", {28'd0, sel}, 32'h8);
    chk("sub_op_a", op_a, 32'd7);
    chk("sub_op_b", op_b, 32'd9);
    chk("sub_dest", {27'd0, dest}, 32'd3);

    issue(enc_i(12'h403, 5'd4, 3'd5, 5'd4, 7'h13), 32'h10, st);
    chk("srai_sel", {28'd0, sel}, 32'hD);
    chk("srai_shamt", {27'd0, op_b[4:0]}, 32'd3);

    issue(enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13), 32'h14, st);
    issue(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 32'h18, st);
    chk("raw_stalls", st, 32'd2);
    chk("raw_op_a", op_a, 32'd1);

    issue({20'h12345, 5'd5, 7'h37}, 32'h1C, st);
    chk("lui_op_b", op_b, 32'h12345000);
    issue({20'h00001, 5'd6, 7'h17}, 32'h100, st);
    chk("auipc_op_a", op_a, 32'h100);
    chk("auipc_op_b", op_b, 32'h1000);

    issue(enc_i(12'd0, 5'd1, 3'd2, 5'd7, 7'h03), 32'h104, st);
    chk("load_illegal", {31'd0, ill}, 32'd1);
    step(1'b0, 32'h0, 32'h0, acc);
    chk("illegal_pulse", {31'd0, ill}, 32'd0);
    issue(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3), 32'h108, st);
    chk("mul_illegal", {31'd0, ill}, 32'd1);
    issue(enc_i(12'd1, 5'd1, 3'd0, 5'd0, 7'h13), 32'h10C, st);
    chk("x0_wb", {31'd0, wb}, 32'd0);

    issue(enc_i(12'd3, 5'd0, 3'd0, 5'd7, 7'h13), 32'h110, st);
    step(1'b1, enc_r(7'h00, 5'd7, 5'd7, 3'd0, 5'd6), 32'h114, acc);
    chk("stall_before_reset", {31'd0, acc}, 32'd0);
    do_reset();
    issue(enc_r(7'h00, 5'd7, 5'd7, 3'd0, 5'd6), 32'h114, st);
    chk("no_replay_stalls", st, 32'd0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) step(1'b0, $urandom, $urandom, acc);
      issue(rand_instr(), {$urandom_range(0, 32'hFFFF), 2'b00}, st);
    end
    step(1'b0, 32'h0, 32'h0, acc);
    check_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
